// File: rtl/bus_arbiter.sv
// bus_arbiter: three-master arbiter for the shared external memory bus
// (16-bit address, 8-bit data) of the Z80 computer.
//   M0 = video fetch (read-only), M1 = UART debug, M2 = tv80 CPU.
// One master owns the bus at a time. Its address/data/strobe are routed to
// the bus, the slave ack is returned to it, and every access is bounded by
// a timeout that aborts it with an error pulse.
//
// Parameters
//   ROUND_ROBIN : 0 = fixed priority M0 > M1 > M2
//                 1 = rotating priority, search starts after the last grant
//   TIMEOUT     : ACCESS cycles without i_ack before abort; 0 disables it
//
// Ports
//   i_clk, i_reset           clock, synchronous active-high reset
//   i_mN_cs/_we/_addr/_dat   master requests (M0 has no we/dat)
//   o_mN_ack, o_mN_err       per-master completion / timeout abort
//   o_addr, o_dat, o_we, o_cs shared bus
//   i_ack                    slave acknowledge
//   o_grant                  one-hot current owner, 0 when idle
module bus_arbiter #(
  parameter int ROUND_ROBIN = 0,
  parameter int TIMEOUT     = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_m0_cs,
  input  logic [15:0] i_m0_addr,
  input  logic        i_m1_cs,
  input  logic        i_m1_we,
  input  logic [15:0] i_m1_addr,
  input  logic [7:0]  i_m1_dat,
  input  logic        i_m2_cs,
  input  logic        i_m2_we,
  input  logic [15:0] i_m2_addr,
  input  logic [7:0]  i_m2_dat,
  output logic        o_m0_ack,
  output logic        o_m1_ack,
  output logic        o_m2_ack,
  output logic        o_m0_err,
  output logic        o_m1_err,
  output logic        o_m2_err,
  output logic [15:0] o_addr,
  output logic [7:0]  o_dat,
  output logic        o_we,
  output logic        o_cs,
  input  logic        i_ack,
  output logic [2:0]  o_grant
);

  // Counter is at least one bit wide so TIMEOUT=0 still elaborates.
  localparam int CNT_W_C = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W_C-1:0] CNT_LAST_C = CNT_W_C'(TIMEOUT - 1);
  localparam logic [CNT_W_C-1:0] CNT_MAX_C  = {CNT_W_C{1'b1}};
  localparam logic [CNT_W_C-1:0] CNT_ONE_C  = CNT_W_C'(1);
  localparam logic [CNT_W_C-1:0] CNT_ZERO_C = {CNT_W_C{1'b0}};
  localparam bit TO_EN_C = (TIMEOUT > 0);
  localparam bit RR_EN_C = (ROUND_ROBIN != 0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t               state_r, state_nxt_s;
  logic [2:0]           grant_r, grant_nxt_s;
  logic [1:0]           last_r, last_nxt_s;
  logic [CNT_W_C-1:0]   cnt_r, cnt_nxt_s;
  logic [2:0]           req_s;
  logic [1:0]           start_s;
  logic [1:0]           win_s;
  logic                 gnt_cs_s;
  logic                 timeout_s;

  // Master index that follows idx in the rotation 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] next_idx_f(input logic [1:0] idx);
    logic [1:0] res;
    case (idx)
      2'd0:    res = 2'd1;
      2'd1:    res = 2'd2;
      default: res = 2'd0;
    endcase
    return res;
  endfunction

  // First requesting master found when searching from start in rotation order.
  function automatic logic [1:0] pick_f(input logic [2:0] req, input logic [1:0] start);
    logic [1:0] idx;
    logic [1:0] res;
    logic       found;
    idx   = start;
    res   = 2'd0;
    found = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (!found && req[idx]) begin
        res   = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
      idx = next_idx_f(idx);
    end
    return res;
  endfunction

  // One-hot grant vector for a master index.
  function automatic logic [2:0] onehot_f(input logic [1:0] idx);
    logic [2:0] res;
    case (idx)
      2'd0:    res = 3'b001;
      2'd1:    res = 3'b010;
      2'd2:    res = 3'b100;
      default: res = 3'b000;
    endcase
    return res;
  endfunction

  assign req_s   = {i_m2_cs, i_m1_cs, i_m0_cs};
  // Fixed priority is a rotating search that always starts at M0.
  assign start_s = RR_EN_C ? next_idx_f(last_r) : 2'd0;
  assign win_s   = pick_f(req_s, start_s);
  assign o_grant = grant_r;

  // Request line of whichever master currently owns the bus.
  always_comb begin
    gnt_cs_s = 1'b0;
    case (grant_r)
      3'b001:  gnt_cs_s = i_m0_cs;
      3'b010:  gnt_cs_s = i_m1_cs;
      3'b100:  gnt_cs_s = i_m2_cs;
      default: gnt_cs_s = 1'b0;
    endcase
  end

  // Next-state logic: arbitration, ack/timeout/abort handling, release wait.
  always_comb begin
    state_nxt_s = state_r;
    grant_nxt_s = grant_r;
    last_nxt_s  = last_r;
    cnt_nxt_s   = cnt_r;
    timeout_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (|req_s) begin
          state_nxt_s = ST_ACCESS;
          grant_nxt_s = onehot_f(win_s);
          last_nxt_s  = win_s;
          cnt_nxt_s   = CNT_ZERO_C;
        end else begin
          grant_nxt_s = 3'b000;
        end
      end
      ST_ACCESS: begin
        // Ack beats both abort and timeout in the same cycle.
        if (i_ack) begin
          state_nxt_s = ST_RELEASE;
        end else if (!gnt_cs_s) begin
          state_nxt_s = ST_IDLE;
          grant_nxt_s = 3'b000;
        end else if (TO_EN_C && (cnt_r == CNT_LAST_C)) begin
          timeout_s   = 1'b1;
          state_nxt_s = ST_RELEASE;
        end else if (cnt_r != CNT_MAX_C) begin
          cnt_nxt_s = cnt_r + CNT_ONE_C;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      ST_RELEASE: begin
        // Hold ownership until the strobe drops so a held Z80 cs cannot
        // start a duplicate access.
        if (!gnt_cs_s) begin
          state_nxt_s = ST_IDLE;
          grant_nxt_s = 3'b000;
        end else begin
          state_nxt_s = ST_RELEASE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        grant_nxt_s = 3'b000;
      end
    endcase
  end

  // State, grant, last-grant and wait-counter registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r <= ST_IDLE;
      grant_r <= 3'b000;
      last_r  <= 2'd2;
      cnt_r   <= CNT_ZERO_C;
    end else begin
      state_r <= state_nxt_s;
      grant_r <= grant_nxt_s;
      last_r  <= last_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Bus and per-master response routing; everything is 0 outside ACCESS.
  always_comb begin
    o_cs     = 1'b0;
    o_addr   = 16'h0000;
    o_dat    = 8'h00;
    o_we     = 1'b0;
    o_m0_ack = 1'b0;
    o_m1_ack = 1'b0;
    o_m2_ack = 1'b0;
    o_m0_err = 1'b0;
    o_m1_err = 1'b0;
    o_m2_err = 1'b0;
    if (state_r == ST_ACCESS) begin
      o_cs = 1'b1;
      case (grant_r)
        3'b001: begin
          // Video fetch is read-only: no write strobe, no write data.
          o_addr   = i_m0_addr;
          o_m0_ack = i_ack;
          o_m0_err = timeout_s;
        end
        3'b010: begin
          o_addr   = i_m1_addr;
          o_dat    = i_m1_dat;
          o_we     = i_m1_we;
          o_m1_ack = i_ack;
          o_m1_err = timeout_s;
        end
        3'b100: begin
          o_addr   = i_m2_addr;
          o_dat    = i_m2_dat;
          o_we     = i_m2_we;
          o_m2_ack = i_ack;
          o_m2_err = timeout_s;
        end
        default: begin
          o_cs = 1'b0;
        end
      endcase
    end else begin
      o_cs = 1'b0;
    end
  end

endmodule
